// File: rtl/event_dispatch_ctrl_pkg.sv
// Shared phold definitions for the event dispatch controller.
// Message layout:
//   [TIME_WID-1:0]          timestamp
//   [LP_OFS +: LP_ID_W]     target logical process id
//   [ANTI_BIT]              anti-message flag (carried through untouched)
// Also holds the dispatcher FSM state encoding.
package event_dispatch_ctrl_pkg;

  localparam int MSG_WID  = 32;
  localparam int TIME_WID = 16;
  localparam int LP_OFS   = TIME_WID;
  localparam int LP_ID_W  = 3;
  localparam int ANTI_BIT = 19;

  localparam int DEF_NUM_CORE = 4;
  localparam int DEF_NUM_LP   = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_DRAIN    = 2'd2
  } disp_state_e;

  // Index width that stays legal for a single-entry range.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/event_dispatch_ctrl_rr_core_sel.sv
// Round-robin core selector.
// Picks the first asserted request at or after ptr, wrapping modulo NUM_CORE.
// Ports:
//   req        in   NUM_CORE  eligible cores (ready and not reserved)
//   ptr        in   IW        starting search index
//   grant_idx  out  IW        selected core (0 when nothing eligible)
//   grant_vld  out  1         some core was eligible
module rr_core_sel
  import event_dispatch_ctrl_pkg::*;
#(
  parameter  int NUM_CORE = DEF_NUM_CORE,
  localparam int IW       = idx_w(NUM_CORE)
) (
  input  logic [NUM_CORE-1:0] req,
  input  logic [IW-1:0]       ptr,
  output logic [IW-1:0]       grant_idx,
  output logic                grant_vld
);

  logic [IW:0] sum;

  // Walk offsets from far to near so the nearest eligible core wins.
  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    sum       = '0;
    for (int k = NUM_CORE - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(NUM_CORE)) sum = sum - (IW+1)'(NUM_CORE);
      if (req[sum[IW-1:0]]) begin
        grant_idx = sum[IW-1:0];
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/event_dispatch_ctrl.sv
// Event dispatch controller for a phold-style PDES engine.
// Pops the minimum-timestamp event from a priority queue and hands it to a
// free core, never running two events of the same logical process at once.
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   run                1 = dispatch, 0 = drain outstanding work and go idle
//   q_empty/q_head     priority queue status and head message
//   q_deq              combinational pop strobe (same cycle as the decision)
//   core_ready         per-core accept capability
//   core_done          per-core completion pulse, frees the core and its LP
//   disp_vld/disp_msg  registered one-hot dispatch strobe and message
//   lp_busy            registered per-LP occupancy
//   active_cnt         registered number of reserved cores
//   blocked            head-of-line LP was busy in the previous cycle
//   blk_cycles         saturating count of blocked cycles
//   idle               FSM is in IDLE
module event_dispatch_ctrl
  import event_dispatch_ctrl_pkg::*;
#(
  parameter  int NUM_CORE = DEF_NUM_CORE,
  parameter  int NUM_LP   = DEF_NUM_LP,
  parameter  int TIME_WID = event_dispatch_ctrl_pkg::TIME_WID,
  parameter  int MSG_WID  = event_dispatch_ctrl_pkg::MSG_WID,
  localparam int CW       = $clog2(NUM_CORE) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                q_empty,
  input  logic [MSG_WID-1:0]  q_head,
  output logic                q_deq,
  input  logic [NUM_CORE-1:0] core_ready,
  input  logic [NUM_CORE-1:0] core_done,
  output logic [NUM_CORE-1:0] disp_vld,
  output logic [MSG_WID-1:0]  disp_msg,
  output logic [NUM_LP-1:0]   lp_busy,
  output logic [CW-1:0]       active_cnt,
  output logic                blocked,
  output logic [15:0]         blk_cycles,
  output logic                idle
);

  localparam int LPW = idx_w(NUM_LP);
  localparam int CIW = idx_w(NUM_CORE);

  disp_state_e                    state;
  logic [NUM_CORE-1:0]            rsv;
  logic [NUM_CORE-1:0][LPW-1:0]   core_lp;
  logic [CIW-1:0]                 rr_ptr;

  logic [LPW-1:0]                 head_lp;
  logic                           head_busy;
  logic                           grant_vld;
  logic [CIW-1:0]                 grant_idx;
  logic                           dispatch;
  logic                           blk_cond;
  logic [NUM_CORE-1:0]            rel;
  logic [NUM_CORE-1:0]            rsv_nxt;
  logic [NUM_LP-1:0]              busy_nxt;
  logic [CW-1:0]                  cnt_nxt;

  assign head_lp   = q_head[LP_OFS +: LPW];
  assign head_busy = lp_busy[head_lp];

  rr_core_sel #(.NUM_CORE(NUM_CORE)) u_sel (
    .req       (core_ready & ~rsv),
    .ptr       (rr_ptr),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  // All inputs to the decision are registered state, so a release in this
  // cycle only becomes visible to the next decision; same-LP release and
  // dispatch therefore never collide. Reset masks the pop so the queue is
  // not drained into a controller that is about to forget it.
  assign dispatch = !reset && (state == ST_DISPATCH) && !q_empty &&
                    !head_busy && grant_vld;
  assign q_deq    = dispatch;
  assign blk_cond = (state == ST_DISPATCH) && !q_empty && head_busy;

  // Completions from unreserved cores are dropped here.
  assign rel = core_done & rsv;

  always_comb begin
    rsv_nxt  = rsv & ~rel;
    busy_nxt = lp_busy;
    for (int i = 0; i < NUM_CORE; i++)
      if (rel[i]) busy_nxt[core_lp[i]] = 1'b0;
    if (dispatch) begin
      rsv_nxt[grant_idx] = 1'b1;
      busy_nxt[head_lp]  = 1'b1;
    end
    cnt_nxt = '0;
    for (int i = 0; i < NUM_CORE; i++)
      cnt_nxt = cnt_nxt + CW'(rsv_nxt[i]);
  end

  // Control FSM; idle is registered alongside the state it mirrors.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      idle  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: if (run) begin
          state <= ST_DISPATCH;
          idle  <= 1'b0;
        end
        ST_DISPATCH: if (!run) state <= ST_DRAIN;
        ST_DRAIN: begin
          if (run) begin
            state <= ST_DISPATCH;
          end else if (active_cnt == '0) begin
            state <= ST_IDLE;
            idle  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          idle  <= 1'b1;
        end
      endcase
    end
  end

  // Reservation bookkeeping and dispatch outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsv        <= '0;
      core_lp    <= '0;
      lp_busy    <= '0;
      active_cnt <= '0;
      rr_ptr     <= '0;
      disp_vld   <= '0;
      disp_msg   <= '0;
      blocked    <= 1'b0;
      blk_cycles <= '0;
    end else begin
      rsv        <= rsv_nxt;
      lp_busy    <= busy_nxt;
      active_cnt <= cnt_nxt;
      disp_vld   <= '0;
      if (dispatch) begin
        core_lp[grant_idx]  <= head_lp;
        disp_vld[grant_idx] <= 1'b1;
        disp_msg            <= q_head;
        rr_ptr <= (grant_idx == CIW'(NUM_CORE - 1)) ? '0 : grant_idx + 1'b1;
      end
      blocked <= blk_cond;
      if (blk_cond && blk_cycles != 16'hFFFF)
        blk_cycles <= blk_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_event_dispatch_ctrl.sv
// Bench for event_dispatch_ctrl: directed scenarios plus random traffic,
// every cycle compared against a cycle-level behavioural model.
module tb_event_dispatch_ctrl;

  localparam int NC = 4;
  localparam int NL = 8;
  localparam int TW = 16;
  localparam int MW = 32;
  localparam int CW = $clog2(NC) + 1;

  logic          clk = 1'b0;
  logic          reset, run, q_empty, q_deq;
  logic [MW-1:0] q_head, disp_msg;
  logic [NC-1:0] core_ready, core_done, disp_vld;
  logic [NL-1:0] lp_busy;
  logic [CW-1:0] active_cnt;
  logic          blocked, idle;
  logic [15:0]   blk_cycles;

  always #5 clk = ~clk;

  event_dispatch_ctrl #(.NUM_CORE(NC), .NUM_LP(NL), .TIME_WID(TW), .MSG_WID(MW)) dut (
    .clk(clk), .reset(reset), .run(run), .q_empty(q_empty), .q_head(q_head),
    .q_deq(q_deq), .core_ready(core_ready), .core_done(core_done),
    .disp_vld(disp_vld), .disp_msg(disp_msg), .lp_busy(lp_busy),
    .active_cnt(active_cnt), .blocked(blocked), .blk_cycles(blk_cycles),
    .idle(idle)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---- behavioural model: modes 0 idle, 1 dispatching, 2 draining ----
  logic [MW-1:0] q[$];
  int            m_mode;
  bit            m_rsv[NC];
  int            m_lp[NC];
  bit            m_busy[NL];
  int            m_ptr, m_blk;
  logic [NC-1:0] m_dvld;
  logic [MW-1:0] m_dmsg;
  bit            m_blocked, m_idle;

  function automatic int m_cnt();
    int c = 0;
    for (int i = 0; i < NC; i++) c += int'(m_rsv[i]);
    return c;
  endfunction

  function automatic logic [NL-1:0] m_busy_vec();
    logic [NL-1:0] v = '0;
    for (int i = 0; i < NL; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic m_reset();
    m_mode = 0; m_ptr = 0; m_blk = 0; m_dvld = '0; m_dmsg = '0;
    m_blocked = 0; m_idle = 1;
    for (int i = 0; i < NC; i++) begin m_rsv[i] = 0; m_lp[i] = 0; end
    for (int i = 0; i < NL; i++) m_busy[i] = 0;
  endtask

  function automatic logic [MW-1:0] mk(input int anti, input int lp, input int ts);
    logic [MW-1:0] m;
    m = MW'($urandom);
    m[TW-1:0] = TW'(ts);
    m[TW+:3]  = 3'(lp);
    m[19]     = anti[0];
    return m;
  endfunction

  // One clock: present queue head, check the pop strobe before the edge,
  // advance the model at the edge, then check registered outputs.
  task automatic step();
    bit ne, dq, blk_now;
    bit rdy[NC];
    bit dn[NC];
    int hl, g, c0;
    ne      = (q.size() != 0);
    q_empty = !ne;
    q_head  = ne ? q[0] : MW'($urandom);
    hl      = int'(q_head[TW+:3]);
    for (int i = 0; i < NC; i++) begin rdy[i] = core_ready[i]; dn[i] = core_done[i]; end
    g = -1;
    for (int k = 0; k < NC; k++) begin
      int j;
      j = (m_ptr + k) % NC;
      if (g < 0 && rdy[j] && !m_rsv[j]) g = j;
    end
    dq      = !reset && m_mode == 1 && ne && !m_busy[hl] && g >= 0;
    blk_now = m_mode == 1 && ne && m_busy[hl];
    @(negedge clk);
    chk("q_deq", q_deq, dq);
    @(posedge clk);
    if (reset) begin
      m_reset();
    end else begin
      c0 = m_cnt();
      for (int i = 0; i < NC; i++)
        if (dn[i] && m_rsv[i]) begin m_rsv[i] = 0; m_busy[m_lp[i]] = 0; end
      m_dvld = '0;
      if (dq) begin
        m_rsv[g] = 1; m_lp[g] = hl; m_busy[hl] = 1;
        m_ptr  = (g + 1) % NC;
        m_dvld = NC'(1) << g;
        m_dmsg = q.pop_front();
      end
      m_blocked = blk_now;
      if (blk_now && m_blk < 65535) m_blk++;
      case (m_mode)
        0: if (run) m_mode = 1;
        1: if (!run) m_mode = 2;
        default: if (run) m_mode = 1; else if (c0 == 0) m_mode = 0;
      endcase
      m_idle = (m_mode == 0);
    end
    #1;
    chk("disp_vld", disp_vld, m_dvld);
    chk("disp_msg", disp_msg, m_dmsg);
    chk("lp_busy", lp_busy, m_busy_vec());
    chk("active_cnt", active_cnt, m_cnt());
    chk("blocked", blocked, m_blocked);
    chk("blk_cycles", blk_cycles, m_blk);
    chk("idle", idle, m_idle);
    core_done = '0;
  endtask

  initial begin
    reset = 1; run = 0; core_ready = '0; core_done = '0; q_empty = 1; q_head = '0;
    m_reset();
    step(); step();
    reset = 0;

    // first dispatch: LP3 t=10 to core 0
    run = 1; core_ready = '1;
    q.push_back(mk(0, 3, 10));
    repeat (4) step();
    chk("s1_lp_busy", lp_busy, 32'h08);
    chk("s1_cnt", active_cnt, 1);
    chk("s1_msg_ts", disp_msg[TW-1:0], 10);

    // same LP again: held while LP3 busy, then to core 1
    q.push_back(mk(1, 3, 20));
    repeat (3) step();
    chk("s2_blocked", blocked, 1);
    chk("s2_blk", blk_cycles, 3);
    core_done = 4'b0001; step();
    step();
    chk("s2_vld", disp_vld, 4'b0010);
    core_done = 4'b0010; step(); step();

    // four LPs to cores 0..3 in order, fifth waits for a release
    reset = 1; step(); reset = 0;
    for (int i = 0; i < 5; i++) q.push_back(mk(0, i, 30 + i));
    repeat (6) step();
    chk("s3_cnt", active_cnt, 4);
    chk("s3_vld", disp_vld, 0);
    core_done = 4'b0100; step(); step();
    chk("s3_vld2", disp_vld, 4'b0100);

    // two releases and one dispatch in the same cycle
    core_done = 4'b1000; step();
    q.push_back(mk(0, 5, 40));
    core_done = 4'b0110; step();
    chk("s4_cnt", active_cnt, 2);
    chk("s4_lp_busy", lp_busy, 32'h21);

    // drain with two reserved cores
    run = 0; step();
    q.push_back(mk(0, 7, 50));
    repeat (3) step();
    chk("s5_idle0", idle, 0);
    core_done = 4'b1001; step(); step();
    chk("s5_idle1", idle, 1);

    // reset with three reserved, stale done afterwards
    run = 1;
    q.push_back(mk(0, 1, 60));
    q.push_back(mk(1, 2, 61));
    repeat (5) step();
    chk("s6_cnt", active_cnt, 3);
    reset = 1; step(); reset = 0;
    chk("s6_rst_cnt", active_cnt, 0);
    chk("s6_rst_idle", idle, 1);
    run = 0; core_done = 4'b0001; step();
    chk("s6_stale_cnt", active_cnt, 0);
    chk("s6_stale_busy", lp_busy, 0);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      run        = ($urandom_range(0, 19) != 0);
      core_ready = NC'($urandom);
      core_done  = NC'($urandom) & NC'($urandom);
      reset      = ($urandom_range(0, 499) == 0);
      if (q.size() < 6 && $urandom_range(0, 2) == 0)
        q.push_back(mk(int'($urandom_range(0, 1)), int'($urandom_range(0, NL - 1)), int'($urandom)));
      step();
    end

    // blocked-cycle counter saturation
    reset = 1; q.delete(); step(); reset = 0;
    run = 1; core_ready = '1;
    q.push_back(mk(0, 2, 1));
    q.push_back(mk(0, 2, 2));
    repeat (65540) step();
    chk("sat_blk", blk_cycles, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
